// File: rtl/i2c_target.sv
// i2c_target: memory-mapped I2C target (slave) peripheral.
// Answers one 7-bit address, collects master-write bytes in an RX FIFO and
// returns a CPU-loaded byte on master reads. CPU side: word-indexed registers
// CTRL / STATUS / TXDATA / RXDATA on addr[3:2].
// Optional feature: define I2C_STRETCH_EN to add scl_oe clock stretching
// (hold SCL on TX underrun or RX FIFO full instead of flagging an error).
`timescale 1ns/1ps
module i2c_target #(
    parameter int         RX_DEPTH   = 4,
    parameter logic [6:0] RESET_ADDR = 7'h42
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        scl_in,
    input  logic        sda_in,
`ifdef I2C_STRETCH_EN
    output logic        scl_oe,
`endif
    output logic        sda_oe
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(RX_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_RX       = 3'd3;
    localparam logic [2:0] S_RX_ACK   = 3'd4;
    localparam logic [2:0] S_TX       = 3'd5;
    localparam logic [2:0] S_TX_ACK   = 3'd6;
    localparam logic [2:0] S_WAIT     = 3'd7;

    // Pin synchronizers plus one delayed copy for edge detection
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // CPU-visible registers
    logic       r_en;
    logic [6:0] r_own_addr;
    logic       r_busy, r_rx_ovf, r_tx_unf, r_stop_seen, r_tx_full;
    logic [7:0] r_tx_hold;

    // RX FIFO
    logic [7:0]    r_fifo [RX_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;

    // Bus engine
    logic [2:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw, r_ack, r_sda_oe;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_run;
    logic w_wr_ctrl, w_wr_stat, w_wr_tx, w_wr_rx;
    logic w_fifo_full, w_fifo_empty, w_pop, w_push, w_room;
    logic w_rx_done, w_addr_match, w_tx_req, w_tx_load;
    logic w_ovf_set, w_unf_set, w_tx_hold, w_rx_hold, w_tx_stalled, w_rx_stalled;
    logic [7:0] w_load_byte;
    logic w_unused;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    // Bus engine advances only when enabled and no START/STOP overrides it
    assign w_run      = r_en & ~w_start & ~w_stop;

    assign w_wr_ctrl = write_enable & (addr[3:2] == 2'd0);
    assign w_wr_stat = write_enable & (addr[3:2] == 2'd1);
    assign w_wr_tx   = write_enable & (addr[3:2] == 2'd2);
    assign w_wr_rx   = write_enable & (addr[3:2] == 2'd3);

    assign w_fifo_full  = (r_count == DEPTH_C);
    assign w_fifo_empty = (r_count == {(PW + 1){1'b0}});
    assign w_pop        = w_wr_rx & ~w_fifo_empty;
    // A pop in the same cycle frees a slot for the incoming byte
    assign w_room       = ~w_fifo_full | w_pop;

    assign w_rx_done    = w_run & (r_state == S_RX) & w_scl_fall & (r_bit_cnt == 4'd8);
    assign w_addr_match = w_run & (r_state == S_ADDR) & w_scl_fall & (r_bit_cnt == 4'd8)
                          & (r_shift[7:1] == r_own_addr);
    assign w_tx_req     = w_run & w_scl_fall &
                          (((r_state == S_ADDR_ACK) & r_rw) | ((r_state == S_TX_ACK) & ~r_ack));
    assign w_load_byte  = r_tx_full ? r_tx_hold : 8'hFF;

`ifdef I2C_STRETCH_EN
    logic r_scl_oe, r_tx_stall, r_rx_stall;
    assign w_tx_stalled = r_tx_stall;
    assign w_rx_stalled = r_rx_stall;
    assign w_tx_hold    = w_tx_req & ~r_tx_full;
    assign w_rx_hold    = w_rx_done & ~w_room;
    assign w_tx_load    = (w_tx_req | (w_run & r_tx_stall)) & r_tx_full;
    assign w_push       = (w_rx_done | (w_run & r_rx_stall)) & w_room;
    assign w_ovf_set    = 1'b0;
    assign w_unf_set    = 1'b0;
    assign scl_oe       = r_scl_oe;

    // Clock-stretch control: hold SCL until TXDATA is written or a pop frees room
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_scl_oe   <= 1'b0;
            r_tx_stall <= 1'b0;
            r_rx_stall <= 1'b0;
        end else if (!r_en || w_start || w_stop) begin
            r_scl_oe   <= 1'b0;
            r_tx_stall <= 1'b0;
            r_rx_stall <= 1'b0;
        end else begin
            r_tx_stall <= w_tx_hold | (r_tx_stall & ~w_tx_load);
            r_rx_stall <= w_rx_hold | (r_rx_stall & ~w_push);
            // SCL is released one cycle after the stall ends so SDA settles first
            r_scl_oe   <= w_tx_hold | w_rx_hold | r_tx_stall | r_rx_stall;
        end
    end
`else
    assign w_tx_stalled = 1'b0;
    assign w_rx_stalled = 1'b0;
    assign w_tx_hold    = 1'b0;
    assign w_rx_hold    = 1'b0;
    assign w_tx_load    = w_tx_req;
    assign w_push       = w_rx_done & w_room;
    assign w_ovf_set    = w_rx_done & ~w_room;
    assign w_unf_set    = w_tx_req & ~r_tx_full;
`endif

    assign sda_oe   = r_sda_oe;
    assign w_unused = ^{data_in[31:8], addr[1:0], w_rx_hold};

    // Two-flop synchronizers and edge-detect delay stage for SCL/SDA
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;   r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda_in;   r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    // CPU registers and sticky status; a hardware set beats a CPU clear
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_en        <= 1'b0;
            r_own_addr  <= RESET_ADDR;
            r_busy      <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_tx_unf    <= 1'b0;
            r_stop_seen <= 1'b0;
            r_tx_full   <= 1'b0;
            r_tx_hold   <= 8'hFF;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= data_in[0];
                r_own_addr <= data_in[7:1];
            end
            // A same-cycle load consumes the old byte; the new write stays pending
            if (w_wr_tx) begin
                r_tx_hold <= data_in[7:0];
                r_tx_full <= 1'b1;
            end else if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end
            if (w_addr_match) begin
                r_busy <= 1'b1;
            end else if (w_stop || !r_en) begin
                r_busy <= 1'b0;
            end
            r_rx_ovf    <= w_ovf_set | (r_rx_ovf & ~(w_wr_stat & data_in[2]));
            r_tx_unf    <= w_unf_set | (r_tx_unf & ~(w_wr_stat & data_in[4]));
            r_stop_seen <= (w_stop & r_busy) | (r_stop_seen & ~(w_wr_stat & data_in[5]));
        end
    end

    // RX FIFO storage, pointers and occupancy
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {(PW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= r_shift;
                r_wptr         <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus protocol FSM: bit shifting, ACK generation and SDA drive
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_ack     <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else if (!r_en) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
        end else if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
        end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        r_shift   <= {r_shift[6:0], r_sda_s2};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift[7:1] == r_own_addr) begin
                            r_state  <= S_ADDR_ACK;
                            r_rw     <= r_shift[0];
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_state  <= S_WAIT;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall && !r_rw) begin
                        r_state   <= S_RX;
                        r_bit_cnt <= 4'd0;
                        r_sda_oe  <= 1'b0;
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        r_shift   <= {r_shift[6:0], r_sda_s2};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        r_state  <= S_RX_ACK;
                        r_sda_oe <= w_push;
                    end
                end
                S_RX_ACK: begin
                    if (w_rx_stalled) begin
                        if (w_push) begin
                            r_sda_oe <= 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        r_state   <= S_RX;
                        r_bit_cnt <= 4'd0;
                        r_sda_oe  <= 1'b0;
                    end
                end
                S_TX: begin
                    if (w_scl_fall && !w_tx_stalled) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_state  <= S_TX_ACK;
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_oe  <= ~r_shift[6];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        r_ack <= r_sda_s2;
                    end else if (w_scl_fall && r_ack) begin
                        r_state  <= S_WAIT;
                        r_sda_oe <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_sda_oe <= 1'b0;
                end
                S_IDLE: begin
                    r_sda_oe <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sda_oe <= 1'b0;
                end
            endcase
            // Byte load for master reads: MSB goes out immediately
            if (w_tx_load) begin
                r_state   <= S_TX;
                r_shift   <= w_load_byte;
                r_sda_oe  <= ~w_load_byte[7];
                r_bit_cnt <= 4'd1;
            end else if (w_tx_hold) begin
                r_state  <= S_TX;
                r_sda_oe <= 1'b0;
            end
        end
    end

    // Register read mux
    always_comb begin
        data_out = 32'h0000_0000;
        case (addr[3:2])
            2'd0:    data_out = {24'h000000, r_own_addr, r_en};
            2'd1:    data_out = {26'h0000000, r_stop_seen, r_tx_unf, r_tx_full,
                                 r_rx_ovf, ~w_fifo_empty, r_busy};
            2'd2:    data_out = {24'h000000, r_tx_hold};
            2'd3:    data_out = w_fifo_empty ? 32'h0000_0000 : {24'h000000, r_fifo[r_rptr]};
            default: data_out = 32'h0000_0000;
        endcase
    end

endmodule
